register_file_lvt_multiport: RTL and testbench
==============================================

// Module: register_file_lvt_multiport
// PURPOSE
//  Parametrised W-write/R-read register file built from 1W1R RAM banks plus a live value table (LVT).
//  Each write port owns one bank per read port; the LVT records which write port last wrote each register.
//  A hardware clear sequencer zeroes the file after reset, and same-address write collisions are resolved and flagged.
//  Sits between the issue stage (read ports) and the writeback/commit stage (write ports) of the core.
// PARAMETERS
//  DATA_WIDTH   64                  bits per register
//  REG_COUNT    256                 number of registers (power of two)
//  ADDR_WIDTH   $clog2(REG_COUNT)   register index width
//  WRITE_PORTS  4                   independent write ports (W >= 1)
//  READ_PORTS   8                   independent read ports (R >= 1)
//  ZERO_REG     1                   1: register 0 always reads 0 and writes to it are dropped
// PORTS
//  clk         in   1                       clock; all logic is rising-edge
//  sync_rst    in   1                       synchronous reset, active-high
//  clk_en      in   1                       global enable; 0 freezes all state, outputs hold
//  wr_en       in   WRITE_PORTS             per-port write enable
//  wr_addr     in   ADDR_WIDTH*WRITE_PORTS  write index, port i at [(i+1)*AW-1 -: AW]
//  wr_data     in   DATA_WIDTH*WRITE_PORTS  write data, port i at [(i+1)*DW-1 -: DW]
//  rd_en       in   READ_PORTS              per-port read enable
//  rd_addr     in   ADDR_WIDTH*READ_PORTS   read index, port j at [(j+1)*AW-1 -: AW]
//  rd_data     out  DATA_WIDTH*READ_PORTS   registered read data, port j at [(j+1)*DW-1 -: DW]
//  ready       out  1                       1 = clear finished, ports accepted
//  wr_conflict out  WRITE_PORTS             1-cycle pulse: port i lost a same-address collision
// BEHAVIOUR
//  Reset: rd_data=0, wr_conflict=0, ready=0, state=CLEAR, clear_ptr=0. Reset mid-operation restarts clear.
//  FSM CLEAR: each clk_en cycle writes 0 to address clear_ptr in bank set 0 and sets LVT[clear_ptr]=0;
//   clear_ptr increments; on clear_ptr==REG_COUNT-1 go to READY next cycle (REG_COUNT cycles total).
//   In CLEAR: wr_en ignored, rd_en ignored, rd_data held at 0, wr_conflict=0.
//  FSM READY: ready=1; stays until sync_rst. No other transitions.
//  Write (READY, clk_en=1): port i with wr_en[i] writes wr_data_i into its R banks at wr_addr_i and LVT[addr]=i.
//  Collision: several enabled ports, same address -> highest index wins; each losing port pulses
//   wr_conflict[i] the following cycle; losers' data is discarded.
//  Read: rd_en[j] at edge N -> rd_data_j valid after edge N (1-cycle latency), selected from bank LVT[addr].
//   rd_en[j]=0 -> rd_data_j holds previous value. Any number of read ports may hit the same address.
//  Read/write same address same cycle: read-first (old value) unless bypass is compiled in.
//  ZERO_REG=1: address 0 reads 0, writes to 0 dropped and never counted as collisions.
//  clk_en=0: no writes, no reads, FSM and clear_ptr hold, wr_conflict forced 0.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-first; a read hitting an address written the same cycle returns
//   the winning port's wr_data (highest index), without extra latency.
//  REGFILE_BYPASS_EN undefined: read-first; the same read returns pre-write contents; no bypass muxes.
// TESTING
//  1 Reset 1 cycle, release -> ready=0 for exactly 256 cycles, then 1; read all 256 regs -> all 0.
//  2 Ports 0..3 write 0x11,0x22,0x33,0x44 to r5,r6,r7,r8 same cycle; next cycle 8 ports read r5..r8 twice -> matching data.
//  3 Ports 1 and 3 write 0xAA/0xBB to r9 same cycle -> wr_conflict=4'b0010 one cycle; r9 reads 0xBB.
//  4 r10=0x1; same cycle write 0x2 to r10 and read r10 -> 0x2 with REGFILE_BYPASS_EN, 0x1 without.
//  5 Write 0xFF to r0 (ZERO_REG=1) -> reads 0, wr_conflict=0; reassert sync_rst at clear_ptr=100 -> clear restarts, ready after 256 more cycles.
//  6 clk_en=0 with wr_en/rd_en set for 3 cycles -> no contents change, rd_data held, clear_ptr frozen.

Source files
------------

// File: rtl/register_file_lvt_multiport.sv
// Multi-port register file: WRITE_PORTS x READ_PORTS 1W1R banks plus a live value table, with a post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN: a read of an address written in the same cycle returns the new data (write-first).

module rf_bank #(
  parameter int DW = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module register_file_lvt_multiport #(
  parameter int DATA_WIDTH  = 64,
  parameter int REG_COUNT   = 256,
  parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8,
  parameter int ZERO_REG    = 1
) (
  input  logic                              clk,
  input  logic                              sync_rst,
  input  logic                              clk_en,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr,
  input  logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data,
  input  logic [READ_PORTS-1:0]             rd_en,
  input  logic [ADDR_WIDTH*READ_PORTS-1:0]  rd_addr,
  output logic [DATA_WIDTH*READ_PORTS-1:0]  rd_data,
  output logic                              ready,
  output logic [WRITE_PORTS-1:0]            wr_conflict
);
  localparam int LVT_W = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wa;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wd;
  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  ra;
  assign wa = wr_addr;
  assign wd = wr_data;
  assign ra = rd_addr;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  active, clearing;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clk_en && state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == ADDR_WIDTH'(REG_COUNT - 1)) state_d = READY;
    end
  end

  assign ready    = (state_q == READY);
  assign active   = clk_en && ready && !sync_rst;
  assign clearing = clk_en && (state_q == CLEAR);

  // Highest-index port wins a shared address; writes to r0 are dropped before arbitration.
  logic [WRITE_PORTS-1:0] wr_valid, wr_lose, wr_win;
  always_comb begin
    wr_valid = '0;
    wr_lose  = '0;
    for (int i = 0; i < WRITE_PORTS; i++)
      wr_valid[i] = wr_en[i] && !(ZERO_REG != 0 && wa[i] == '0);
    for (int i = 0; i < WRITE_PORTS; i++)
      for (int k = 0; k < WRITE_PORTS; k++)
        if (k > i && wr_valid[i] && wr_valid[k] && wa[k] == wa[i]) wr_lose[i] = 1'b1;
    wr_win = wr_valid & ~wr_lose & {WRITE_PORTS{active}};
  end

  // Bank set 0 doubles as the clear target while the sequencer runs.
  logic [WRITE_PORTS-1:0]                 bk_we;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] bk_wa;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] bk_wd;
  always_comb begin
    bk_we = wr_win;
    bk_wa = wa;
    bk_wd = wd;
    if (clearing) begin
      bk_we[0] = 1'b1;
      bk_wa[0] = clr_ptr_q;
      bk_wd[0] = '0;
    end
  end

  logic [WRITE_PORTS-1:0][READ_PORTS-1:0][DATA_WIDTH-1:0] bank_rd;

  for (genvar gi = 0; gi < WRITE_PORTS; gi++) begin : g_wp
    for (genvar gj = 0; gj < READ_PORTS; gj++) begin : g_rp
      rf_bank #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_bank (
        .clk   (clk),
        .we    (bk_we[gi]),
        .waddr (bk_wa[gi]),
        .wdata (bk_wd[gi]),
        .raddr (ra[gj]),
        .rdata (bank_rd[gi][gj])
      );
    end
  end

  logic [LVT_W-1:0] lvt [REG_COUNT];
  always_ff @(posedge clk) begin
    if (clearing) lvt[clr_ptr_q] <= '0;
    else
      for (int i = 0; i < WRITE_PORTS; i++)
        if (wr_win[i]) lvt[wa[i]] <= LVT_W'(i);
  end

  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int j = 0; j < READ_PORTS; j++) begin
      rd_val[j] = bank_rd[lvt[ra[j]]][j];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < WRITE_PORTS; i++)
        if (wr_win[i] && wa[i] == ra[j]) rd_val[j] = wd[i];
`endif
      if (ZERO_REG != 0 && ra[j] == '0) rd_val[j] = '0;
    end
  end

  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_q;
  logic [WRITE_PORTS-1:0]                conf_q;
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rd_q   <= '0;
      conf_q <= '0;
    end else begin
      conf_q <= active ? wr_lose : '0;
      for (int j = 0; j < READ_PORTS; j++)
        if (active && rd_en[j]) rd_q[j] <= rd_val[j];
    end
  end

  assign rd_data     = rd_q;
  assign wr_conflict = conf_q;
endmodule

// File: tb/tb_register_file_lvt_multiport.sv
// Randomised and directed bench for register_file_lvt_multiport against an array-based reference model.
module tb_register_file_lvt_multiport;
  logic             clk = 1'b0;
  logic             sync_rst, clk_en;
  logic [3:0]       wr_en;
  logic [3:0][7:0]  wa;
  logic [3:0][63:0] wd;
  logic [7:0]       rd_en;
  logic [7:0][7:0]  ra;
  logic [7:0][63:0] rdq;
  logic             ready;
  logic [3:0]       wr_conflict;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  register_file_lvt_multiport dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_en(rd_en), .rd_addr(ra), .rd_data(rdq),
    .ready(ready), .wr_conflict(wr_conflict)
  );

  logic [63:0] mem [256];
  logic [63:0] exp_rd [8];
  logic [3:0]  exp_conf;
  logic        exp_ready;
  int          clr_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: all enabled non-r0 writes applied in port order, so the highest port's data survives.
  task automatic tick();
    logic [63:0] nxt [256];
    logic [3:0]  cn;
    cn = '0;
    if (sync_rst) begin
      foreach (mem[a]) mem[a] = '0;
      foreach (exp_rd[j]) exp_rd[j] = '0;
      exp_ready = 1'b0;
      clr_cnt   = 0;
    end else if (clk_en && exp_ready) begin
      nxt = mem;
      for (int i = 0; i < 4; i++)
        if (wr_en[i] && wa[i] != 8'd0) begin
          nxt[wa[i]] = wd[i];
          for (int k = i + 1; k < 4; k++)
            if (wr_en[k] && wa[k] == wa[i]) cn[i] = 1'b1;
        end
      for (int j = 0; j < 8; j++)
        if (rd_en[j]) exp_rd[j] = (ra[j] == 8'd0) ? 64'd0 : (BYP ? nxt[ra[j]] : mem[ra[j]]);
      mem = nxt;
    end else if (clk_en) begin
      clr_cnt++;
      if (clr_cnt == 256) exp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_conf = cn;
  endtask

  task automatic step(input string tag);
    tick();
    chk({tag, ".ready"}, 64'(ready), 64'(exp_ready));
    chk({tag, ".conf"}, 64'(wr_conflict), 64'(exp_conf));
    for (int j = 0; j < 8; j++) chk($sformatf("%s.rd%0d", tag, j), rdq[j], exp_rd[j]);
  endtask

  task automatic idle();
    sync_rst = 1'b0;
    clk_en   = 1'b1;
    wr_en    = '0;
    rd_en    = '0;
  endtask

  initial begin
    wa = '0; wd = '0; ra = '0;
    idle();
    sync_rst = 1'b1;
    step("rst");
    sync_rst = 1'b0;
    for (int c = 0; c < 256; c++) step("clr");
    rd_en = 8'hFF;
    for (int b = 0; b < 32; b++) begin
      for (int j = 0; j < 8; j++) ra[j] = 8'(b * 8 + j);
      step("rd_all0");
    end

    // four ports, four addresses, then every read port
    idle();
    wr_en = 4'hF;
    wa = {8'd8, 8'd7, 8'd6, 8'd5};
    wd = {64'h44, 64'h33, 64'h22, 64'h11};
    step("wr4");
    idle();
    rd_en = 8'hFF;
    ra = {8'd8, 8'd7, 8'd6, 8'd5, 8'd8, 8'd7, 8'd6, 8'd5};
    step("rd8");

    // ports 1 and 3 collide on r9
    idle();
    wr_en = 4'b1010;
    wa[1] = 8'd9; wa[3] = 8'd9;
    wd[1] = 64'hAA; wd[3] = 64'hBB;
    step("coll");
    idle();
    rd_en = 8'h01; ra[0] = 8'd9;
    step("coll_rd");
    idle();
    step("coll_gone");

    // same-cycle read/write of r10
    wr_en = 4'b0001; wa[0] = 8'd10; wd[0] = 64'h1;
    step("r10_init");
    wd[0] = 64'h2; rd_en = 8'h01; ra[0] = 8'd10;
    step("r10_rw");
    idle();
    rd_en = 8'h01; ra[0] = 8'd10;
    step("r10_after");

    // r0 writes dropped and never flagged
    idle();
    wr_en = 4'b1100; wa[2] = 8'd0; wa[3] = 8'd0; wd[2] = 64'hFF; wd[3] = 64'hFF;
    rd_en = 8'h02; ra[1] = 8'd0;
    step("r0_wr");
    idle();
    rd_en = 8'h03; ra[0] = 8'd0; ra[1] = 8'd0;
    step("r0_rd");

    // clk_en low: nothing moves
    wr_en = 4'hF;
    wa = {8'd5, 8'd5, 8'd6, 8'd7};
    wd = {64'hDEAD, 64'hBEEF, 64'hCAFE, 64'hF00D};
    rd_en = 8'hFF;
    ra = {8'd9, 8'd10, 8'd5, 8'd6, 8'd7, 8'd8, 8'd5, 8'd6};
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) step("frozen");
    clk_en = 1'b1; wr_en = '0;
    step("thawed");

    // random traffic on a small address window to force collisions
    for (int c = 0; c < 300; c++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      wr_en  = 4'($urandom);
      rd_en  = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        wa[i] = 8'($urandom_range(0, 15));
        wd[i] = {$urandom, $urandom};
      end
      for (int j = 0; j < 8; j++) ra[j] = 8'($urandom_range(0, 15));
      step("rnd");
    end

    // reset during READY, reset again at clear_ptr=100, and a stall mid-clear
    idle();
    sync_rst = 1'b1;
    step("rst2");
    sync_rst = 1'b0;
    wr_en = 4'hF; rd_en = 8'hFF;
    for (int c = 0; c < 100; c++) step("clr2");
    sync_rst = 1'b1;
    step("rst3");
    sync_rst = 1'b0;
    for (int c = 0; c < 50; c++) step("clr3a");
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) step("clr3_stall");
    clk_en = 1'b1;
    for (int c = 0; c < 206; c++) step("clr3b");
    idle();
    rd_en = 8'hFF;
    ra = {8'd15, 8'd14, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    step("post_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
